axiline_inst_decoder: RTL and testbench
=======================================

// Module: axiline_inst_decoder
// PURPOSE
//  Receiving end of the training controller's instruction interface: samples the 3-bit phase code
//  and the xw1/xw2 addresses each cycle and produces registered buffer enables and addresses.
//  Produces latency-matched SGD write-back strobes, per-sample/epoch bookkeeping and an optional
//  protocol checker. Sits between the controller and the x/w buffers plus IP/SGD datapath.
// PARAMETERS
//  logNumCycle   3   address width of xw1/xw2 counters
//  numCycle      8   beats per phase (vector length / lanes)
//  instBitwidth  3   phase-code width
//  SGD_LAT       2   cycles from SGD/PIPE read to updated-weight availability (>=1)
//  CNT_W        16   width of sample counter
// PORTS
//  clk         in   1            clock
//  rst_n       in   1            synchronous reset, active low
//  inst        in   instBitwidth phase code: 0 IDLE,1 INIT,2 INIT_IP,3 IP,4 COMB,5 PIPE,6 SGD,7 illegal
//  sel         in   1            accumulate-select from controller
//  xw1_addr    in   logNumCycle  IP-side beat address
//  xw2_addr    in   logNumCycle  SGD-side beat address
//  w1_we       out  1            weight load strobe (INIT)
//  x1_re       out  1            x read, IP side (INIT_IP, IP, PIPE)
//  w1_re       out  1            w read, IP side (INIT_IP, IP, PIPE)
//  rd1_addr    out  logNumCycle  registered xw1_addr
//  acc_sel     out  1            registered sel; 0 = load first partial, 1 = accumulate
//  comb_en     out  1            combine/loss stage enable (COMB)
//  x2_re       out  1            x read, SGD side (SGD, PIPE)
//  rd2_addr    out  logNumCycle  registered xw2_addr
//  w2_we       out  1            updated-weight write strobe, SGD_LAT after x2_re
//  w2_addr     out  logNumCycle  write address aligned with w2_we
//  sample_done out  1            1-cycle pulse per COMB entry
//  epoch_done  out  1            1-cycle pulse on SGD->IDLE
//  sample_cnt  out  CNT_W        COMB entries since reset; wraps
//  proto_err   out  1            sticky protocol error
//  err_code    out  3            first-error cause
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all outputs 0; prev_inst=IDLE; delay line flushed; err cleared.
//  - Decode latency 1 cycle: outputs at edge N+1 reflect inst/sel/addrs sampled at edge N.
//  - Enables are pure functions of the sampled code; code 7 drives all enables 0.
//  - w2_we/w2_addr = x2_re/rd2_addr delayed SGD_LAT further cycles via shift register.
//  - Entry into IDLE from any phase (controller abort) is legal; pending write-backs still drain.
//  - sample_done asserted when sampled inst=COMB and prev_inst!=COMB; sample_cnt increments then,
//    wrapping 2^CNT_W-1 -> 0.
//  - epoch_done when prev_inst=SGD and inst=IDLE.
//  - prev_inst and prev_xw1/xw2 update every cycle; used only by checker.
// CONFIGURATION
//  AXILINE_DEC_CHECK_EN defined: checker active. Legal transitions (plus any->IDLE, self-loops):
//    IDLE->INIT, INIT->INIT_IP, INIT_IP->COMB, IP->COMB, COMB->SGD, SGD->PIPE, PIPE->IP.
//    Within INIT/INIT_IP/IP, xw1_addr must equal prev+1 (mod numCycle).
//    Leaving INIT/INIT_IP/IP only when prev xw1_addr==numCycle-1.
//  err_code: 1 illegal code 7, 2 illegal transition, 3 address skip, 4 short phase.
//  Error sets proto_err the cycle after the offending sample; err_code latches the first cause.
//  Both hold until reset; simultaneous causes report lowest code.
//  Not defined: proto_err=0, err_code=0, no checker logic synthesised.
// STRUCTURE
//  Shared package/header: phase-code localparams (IDLE..SGD), err_code encodings.
//  Must be the same constants the controller uses.
//  One sub-module: axiline_delay_line (WIDTH, DEPTH=SGD_LAT, sync active-low clear) for w2 path.
// TESTING
//  1 Full epoch, numCycle=8, SGD_LAT=2: IDLE,INIT x8,INIT_IP x8,COMB,SGD,PIPE x7,IP x8,COMB,SGD,IDLE
//    -> w1_we 8 pulses; sample_cnt=2; epoch_done once; proto_err=0.
//  2 SGD with xw2_addr=3 sampled at edge N -> x2_re/rd2_addr=3 at N+1;
//    w2_we with w2_addr=3 at N+3.
//  3 inst=7 for one cycle mid-IP (CHECK_EN) -> enables 0 that cycle; proto_err=1; err_code=1; sticky.
//  4 INIT -> COMB directly -> err_code=2.
//  5 IP with xw1_addr 2 -> 4 -> err_code=3.
//  6 rst_n=0 during PIPE with w2 write pending -> next cycle all outputs 0, no w2_we emitted.
//    Abort to IDLE from IP (no reset) -> no error.

Source files
------------

// File: rtl/axiline_inst_decoder_pkg.sv
// ---------------------------------------------------------------------------
// axiline_inst_decoder_pkg
// Constants shared by the training controller and the instruction decoder:
// phase codes, protocol-error cause codes and small decode helpers.
// The controller must encode phases with exactly these values.
// ---------------------------------------------------------------------------
package axiline_inst_decoder_pkg;

    // Phase codes carried on the instruction interface
    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_INIT    = 3'd1;
    localparam logic [2:0] PH_INIT_IP = 3'd2;
    localparam logic [2:0] PH_IP      = 3'd3;
    localparam logic [2:0] PH_COMB    = 3'd4;
    localparam logic [2:0] PH_PIPE    = 3'd5;
    localparam logic [2:0] PH_SGD     = 3'd6;
    localparam logic [2:0] PH_ILLEGAL = 3'd7;

    // Protocol-error causes; a lower value wins when several fire together
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL_CODE = 3'd1;
    localparam logic [2:0] ERR_BAD_TRANS    = 3'd2;
    localparam logic [2:0] ERR_ADDR_SKIP    = 3'd3;
    localparam logic [2:0] ERR_SHORT_PHASE  = 3'd4;

    // Buffer/stage enables produced for one sampled phase code
    typedef struct packed {
        logic w1_we;
        logic x1_re;
        logic w1_re;
        logic comb_en;
        logic x2_re;
    } dec_en_t;

    // Enables are a pure function of the phase code; the illegal code
    // falls through to the all-zero default.
    function automatic dec_en_t decode_phase(input logic [2:0] code);
        dec_en_t en;
        en = '0;
        case (code)
            PH_INIT:    en.w1_we   = 1'b1;
            PH_INIT_IP: begin en.x1_re = 1'b1; en.w1_re = 1'b1; end
            PH_IP:      begin en.x1_re = 1'b1; en.w1_re = 1'b1; end
            PH_COMB:    en.comb_en = 1'b1;
            PH_PIPE:    begin en.x1_re = 1'b1; en.w1_re = 1'b1; en.x2_re = 1'b1; end
            PH_SGD:     en.x2_re   = 1'b1;
            default:    en = '0;
        endcase
        return en;
    endfunction

    // Phases that stream xw1 addresses and must run a full vector
    function automatic logic is_counted_phase(input logic [2:0] code);
        return (code == PH_INIT) || (code == PH_INIT_IP) || (code == PH_IP);
    endfunction

    // Self-loops and aborts to IDLE are always allowed
    function automatic logic is_legal_transition(input logic [2:0] from_code,
                                                 input logic [2:0] to_code);
        logic ok;
        ok = (from_code == to_code) || (to_code == PH_IDLE);
        ok = ok || (from_code == PH_IDLE    && to_code == PH_INIT);
        ok = ok || (from_code == PH_INIT    && to_code == PH_INIT_IP);
        ok = ok || (from_code == PH_INIT_IP && to_code == PH_COMB);
        ok = ok || (from_code == PH_IP      && to_code == PH_COMB);
        ok = ok || (from_code == PH_COMB    && to_code == PH_SGD);
        ok = ok || (from_code == PH_SGD     && to_code == PH_PIPE);
        ok = ok || (from_code == PH_PIPE    && to_code == PH_IP);
        return ok;
    endfunction

endpackage

// File: rtl/axiline_delay_line.sv
// ---------------------------------------------------------------------------
// axiline_delay_line
// Fixed-depth shift register used to align the updated-weight write strobe
// and address with the SGD datapath latency.
// Ports:
//   clk    in   clock
//   clr_n  in   synchronous clear, active low (flushes every stage)
//   d      in   WIDTH-bit word entering the line
//   q      out  d delayed by DEPTH clock cycles
// ---------------------------------------------------------------------------
module axiline_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per cycle; a clear drops anything in flight so no
    // stale write-back can emerge after a reset.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/axiline_inst_decoder.sv
// ---------------------------------------------------------------------------
// axiline_inst_decoder
// Receiving end of the training controller's instruction interface. Samples
// the phase code and xw1/xw2 beat addresses every cycle and produces
// registered buffer enables/addresses, SGD write-back strobes delayed by
// SGD_LAT, per-sample/epoch bookkeeping and an optional protocol checker.
// Optional feature macro: AXILINE_DEC_CHECK_EN enables the protocol checker;
// without it proto_err and err_code are tied to 0.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   inst, sel             phase code and accumulate-select from controller
//   xw1_addr, xw2_addr    IP-side and SGD-side beat addresses
//   w1_we                 weight load strobe (INIT)
//   x1_re, w1_re          IP-side reads (INIT_IP, IP, PIPE)
//   rd1_addr, acc_sel     registered xw1_addr and sel
//   comb_en               combine/loss stage enable (COMB)
//   x2_re, rd2_addr       SGD-side read (SGD, PIPE) and registered xw2_addr
//   w2_we, w2_addr        updated-weight write, SGD_LAT cycles after x2_re
//   sample_done           pulse per COMB entry
//   epoch_done            pulse on SGD -> IDLE
//   sample_cnt            COMB entries since reset, wrapping
//   proto_err, err_code   sticky protocol error and first cause
// ---------------------------------------------------------------------------
module axiline_inst_decoder
    import axiline_inst_decoder_pkg::*;
#(
    parameter int logNumCycle  = 3,
    parameter int numCycle     = 8,
    parameter int instBitwidth = 3,
    parameter int SGD_LAT      = 2,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [instBitwidth-1:0] inst,
    input  logic                    sel,
    input  logic [logNumCycle-1:0]  xw1_addr,
    input  logic [logNumCycle-1:0]  xw2_addr,
    output logic                    w1_we,
    output logic                    x1_re,
    output logic                    w1_re,
    output logic [logNumCycle-1:0]  rd1_addr,
    output logic                    acc_sel,
    output logic                    comb_en,
    output logic                    x2_re,
    output logic [logNumCycle-1:0]  rd2_addr,
    output logic                    w2_we,
    output logic [logNumCycle-1:0]  w2_addr,
    output logic                    sample_done,
    output logic                    epoch_done,
    output logic [CNT_W-1:0]        sample_cnt,
    output logic                    proto_err,
    output logic [2:0]              err_code
);

    dec_en_t                 en_d;
    logic [instBitwidth-1:0] prev_inst;
    logic [logNumCycle:0]    w2_q;

    assign en_d = decode_phase(inst);

    // One-cycle decode register plus sample/epoch bookkeeping. prev_inst
    // holds the code sampled on the previous edge so phase entries and the
    // SGD->IDLE epoch boundary can be detected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w1_we       <= 1'b0;
            x1_re       <= 1'b0;
            w1_re       <= 1'b0;
            rd1_addr    <= '0;
            acc_sel     <= 1'b0;
            comb_en     <= 1'b0;
            x2_re       <= 1'b0;
            rd2_addr    <= '0;
            sample_done <= 1'b0;
            epoch_done  <= 1'b0;
            sample_cnt  <= '0;
            prev_inst   <= PH_IDLE;
        end else begin
            w1_we       <= en_d.w1_we;
            x1_re       <= en_d.x1_re;
            w1_re       <= en_d.w1_re;
            rd1_addr    <= xw1_addr;
            acc_sel     <= sel;
            comb_en     <= en_d.comb_en;
            x2_re       <= en_d.x2_re;
            rd2_addr    <= xw2_addr;
            sample_done <= (inst == PH_COMB) && (prev_inst != PH_COMB);
            epoch_done  <= (prev_inst == PH_SGD) && (inst == PH_IDLE);
            if ((inst == PH_COMB) && (prev_inst != PH_COMB)) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            prev_inst   <= inst;
        end
    end

    axiline_delay_line #(
        .WIDTH (logNumCycle + 1),
        .DEPTH (SGD_LAT)
    ) u_w2_delay (
        .clk   (clk),
        .clr_n (rst_n),
        .d     ({x2_re, rd2_addr}),
        .q     (w2_q)
    );

    assign {w2_we, w2_addr} = w2_q;

`ifdef AXILINE_DEC_CHECK_EN
    localparam logic [logNumCycle-1:0] LAST_BEAT = logNumCycle'(numCycle - 1);

    logic [logNumCycle-1:0] prev_xw1;
    logic [logNumCycle-1:0] next_xw1;
    logic [2:0]             cause;
    logic                   err_q;
    logic [2:0]             code_q;

    // Classify the current sample against the previous one. The if/else
    // chain gives the lowest-numbered cause priority. Aborts to IDLE are
    // exempt from the short-phase rule.
    always_comb begin
        cause    = ERR_NONE;
        next_xw1 = (prev_xw1 == LAST_BEAT) ? '0 : prev_xw1 + 1'b1;
        if (inst == PH_ILLEGAL) begin
            cause = ERR_ILLEGAL_CODE;
        end else if (!is_legal_transition(prev_inst, inst)) begin
            cause = ERR_BAD_TRANS;
        end else if (is_counted_phase(inst) && (inst == prev_inst) &&
                     (xw1_addr != next_xw1)) begin
            cause = ERR_ADDR_SKIP;
        end else if (is_counted_phase(prev_inst) && (inst != prev_inst) &&
                     (inst != PH_IDLE) && (prev_xw1 != LAST_BEAT)) begin
            cause = ERR_SHORT_PHASE;
        end
    end

    // Sticky error: only the first cause is latched, both hold until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_xw1 <= '0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            prev_xw1 <= xw1_addr;
            if (!err_q && (cause != ERR_NONE)) begin
                err_q  <= 1'b1;
                code_q <= cause;
            end
        end
    end

    assign proto_err = err_q;
    assign err_code  = code_q;
`else
    assign proto_err = 1'b0;
    assign err_code  = ERR_NONE;
`endif

endmodule

// File: tb/tb_axiline_inst_decoder.sv
// ---------------------------------------------------------------------------
// tb_axiline_inst_decoder
// Self-checking bench for axiline_inst_decoder (default parameters:
// numCycle=8, SGD_LAT=2). Uses a table of hand-computed decode vectors plus
// hand-written sequences for reset, write-back latency, a full epoch and the
// protocol checker (AXILINE_DEC_CHECK_EN selects the checker expectations).
// ---------------------------------------------------------------------------
module tb_axiline_inst_decoder;
    import axiline_inst_decoder_pkg::*;

`ifdef AXILINE_DEC_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  inst;
    logic        sel;
    logic [2:0]  xw1_addr;
    logic [2:0]  xw2_addr;
    logic        w1_we, x1_re, w1_re, acc_sel, comb_en, x2_re, w2_we;
    logic [2:0]  rd1_addr, rd2_addr, w2_addr;
    logic        sample_done, epoch_done, proto_err;
    logic [15:0] sample_cnt;
    logic [2:0]  err_code;

    int errors = 0;
    int checks = 0;
    int w1Cnt, w2Cnt, sdCnt, edCnt;

    typedef struct {
        logic [2:0]  inst;
        logic        sel;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [4:0]  en;
        logic        sd;
        logic        ed;
        logic        w2we;
        logic [2:0]  w2a;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [13];

    axiline_inst_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst        (inst),
        .sel         (sel),
        .xw1_addr    (xw1_addr),
        .xw2_addr    (xw2_addr),
        .w1_we       (w1_we),
        .x1_re       (x1_re),
        .w1_re       (w1_re),
        .rd1_addr    (rd1_addr),
        .acc_sel     (acc_sel),
        .comb_en     (comb_en),
        .x2_re       (x2_re),
        .rd2_addr    (rd2_addr),
        .w2_we       (w2_we),
        .w2_addr     (w2_addr),
        .sample_done (sample_done),
        .epoch_done  (epoch_done),
        .sample_cnt  (sample_cnt),
        .proto_err   (proto_err),
        .err_code    (err_code)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive inputs just after an edge, then advance past the next edge
    task automatic applyStimulus(input logic [2:0] i, input logic s,
                                 input logic [2:0] a1, input logic [2:0] a2);
        inst     = i;
        sel      = s;
        xw1_addr = a1;
        xw2_addr = a2;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        rst_n = 1'b1;
    endtask

    task automatic epochStep(input logic [2:0] i, input logic [2:0] a1,
                             input logic [2:0] a2);
        applyStimulus(i, 1'b0, a1, a2);
        w1Cnt += int'(w1_we);
        w2Cnt += int'(w2_we);
        sdCnt += int'(sample_done);
        edCnt += int'(epoch_done);
    endtask

    // Legal path from reset up to and including one PIPE beat
    task automatic runLegalToPipe();
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 8; k++) applyStimulus(PH_INIT, 1'b0, 3'(k), 3'd0);
        for (int k = 0; k < 8; k++) applyStimulus(PH_INIT_IP, 1'b0, 3'(k), 3'd0);
        applyStimulus(PH_COMB, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_SGD, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_PIPE, 1'b0, 3'd0, 3'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        inst     = PH_IDLE;
        sel      = 1'b0;
        xw1_addr = '0;
        xw2_addr = '0;

        // en = {w1_we, x1_re, w1_re, comb_en, x2_re}; w2 = row-2 x2_re/a2
        vecs[0]  = '{PH_IDLE,    1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[1]  = '{PH_INIT,    1'b0, 3'd1, 3'd0, 5'b10000, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[2]  = '{PH_INIT_IP, 1'b1, 3'd2, 3'd1, 5'b01100, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[3]  = '{PH_IP,      1'b0, 3'd3, 3'd0, 5'b01100, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[4]  = '{PH_COMB,    1'b0, 3'd5, 3'd0, 5'b00010, 1'b1, 1'b0, 1'b0, 3'd1, 16'd1};
        vecs[5]  = '{PH_COMB,    1'b0, 3'd0, 3'd0, 5'b00010, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1};
        vecs[6]  = '{PH_SGD,     1'b0, 3'd0, 3'd3, 5'b00001, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1};
        vecs[7]  = '{PH_PIPE,    1'b1, 3'd6, 3'd4, 5'b01101, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1};
        vecs[8]  = '{PH_SGD,     1'b0, 3'd0, 3'd5, 5'b00001, 1'b0, 1'b0, 1'b1, 3'd3, 16'd1};
        vecs[9]  = '{PH_IDLE,    1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b1, 1'b1, 3'd4, 16'd1};
        vecs[10] = '{PH_ILLEGAL, 1'b1, 3'd4, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b1, 3'd5, 16'd1};
        vecs[11] = '{PH_COMB,    1'b0, 3'd0, 3'd0, 5'b00010, 1'b1, 1'b0, 1'b0, 3'd0, 16'd2};
        vecs[12] = '{PH_IDLE,    1'b0, 3'd0, 3'd0, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 16'd2};

        // ---- Table-driven decode vectors ----
        doReset();
        for (int k = 0; k < 13; k++) begin
            applyStimulus(vecs[k].inst, vecs[k].sel, vecs[k].a1, vecs[k].a2);
            checkOutput($sformatf("vec%0d_en", k),
                        {27'd0, w1_we, x1_re, w1_re, comb_en, x2_re}, {27'd0, vecs[k].en});
            checkOutput($sformatf("vec%0d_acc_sel", k), {31'd0, acc_sel}, {31'd0, vecs[k].sel});
            checkOutput($sformatf("vec%0d_rd1_addr", k), {29'd0, rd1_addr}, {29'd0, vecs[k].a1});
            checkOutput($sformatf("vec%0d_rd2_addr", k), {29'd0, rd2_addr}, {29'd0, vecs[k].a2});
            checkOutput($sformatf("vec%0d_sample_done", k), {31'd0, sample_done}, {31'd0, vecs[k].sd});
            checkOutput($sformatf("vec%0d_epoch_done", k), {31'd0, epoch_done}, {31'd0, vecs[k].ed});
            checkOutput($sformatf("vec%0d_w2_we", k), {31'd0, w2_we}, {31'd0, vecs[k].w2we});
            checkOutput($sformatf("vec%0d_w2_addr", k), {29'd0, w2_addr}, {29'd0, vecs[k].w2a});
            checkOutput($sformatf("vec%0d_sample_cnt", k), {16'd0, sample_cnt}, {16'd0, vecs[k].cnt});
        end

        // ---- Reset while busy: every output returns to zero ----
        rst_n = 1'b0;
        applyStimulus(PH_PIPE, 1'b1, 3'd5, 3'd6);
        checkOutput("reset_outputs",
                    {w1_we, x1_re, w1_re, acc_sel, comb_en, x2_re, w2_we, sample_done,
                     epoch_done, proto_err, rd1_addr, rd2_addr, w2_addr, err_code},
                    32'd0);
        checkOutput("reset_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        rst_n = 1'b1;

        // ---- Full epoch ----
        doReset();
        w1Cnt = 0; w2Cnt = 0; sdCnt = 0; edCnt = 0;
        epochStep(PH_IDLE, 3'd0, 3'd0);
        for (int k = 0; k < 8; k++) epochStep(PH_INIT, 3'(k), 3'd0);
        for (int k = 0; k < 8; k++) epochStep(PH_INIT_IP, 3'(k), 3'd0);
        epochStep(PH_COMB, 3'd0, 3'd0);
        epochStep(PH_SGD, 3'd0, 3'd0);
        for (int k = 0; k < 7; k++) epochStep(PH_PIPE, 3'(k), 3'(k + 1));
        for (int k = 0; k < 8; k++) epochStep(PH_IP, 3'(k), 3'd0);
        epochStep(PH_COMB, 3'd0, 3'd0);
        epochStep(PH_SGD, 3'd0, 3'd0);
        epochStep(PH_IDLE, 3'd0, 3'd0);
        epochStep(PH_IDLE, 3'd0, 3'd0);
        epochStep(PH_IDLE, 3'd0, 3'd0);
        checkOutput("epoch_w1_we_pulses", w1Cnt, 32'd8);
        checkOutput("epoch_w2_we_pulses", w2Cnt, 32'd9);
        checkOutput("epoch_sample_done_pulses", sdCnt, 32'd2);
        checkOutput("epoch_epoch_done_pulses", edCnt, 32'd1);
        checkOutput("epoch_sample_cnt", {16'd0, sample_cnt}, 32'd2);
        checkOutput("epoch_proto_err", {31'd0, proto_err}, 32'd0);

        // ---- SGD write-back latency ----
        doReset();
        applyStimulus(PH_SGD, 1'b0, 3'd0, 3'd3);
        checkOutput("lat_x2_re", {31'd0, x2_re}, 32'd1);
        checkOutput("lat_rd2_addr", {29'd0, rd2_addr}, 32'd3);
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        checkOutput("lat_w2_we_early", {31'd0, w2_we}, 32'd0);
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        checkOutput("lat_w2_we", {31'd0, w2_we}, 32'd1);
        checkOutput("lat_w2_addr", {29'd0, w2_addr}, 32'd3);
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        checkOutput("lat_w2_we_after", {31'd0, w2_we}, 32'd0);

        // ---- Reset flushes a pending write-back ----
        doReset();
        applyStimulus(PH_COMB, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_SGD, 1'b0, 3'd0, 3'd6);
        rst_n = 1'b0;
        applyStimulus(PH_PIPE, 1'b1, 3'd2, 3'd7);
        checkOutput("flush_outputs",
                    {w1_we, x1_re, w1_re, acc_sel, comb_en, x2_re, w2_we, sample_done,
                     epoch_done, proto_err, rd1_addr, rd2_addr, w2_addr, err_code},
                    32'd0);
        checkOutput("flush_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        rst_n = 1'b1;
        w2Cnt = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
            w2Cnt += int'(w2_we);
        end
        checkOutput("flush_no_w2_we", w2Cnt, 32'd0);

        // ---- Illegal code mid-IP ----
        doReset();
        runLegalToPipe();
        applyStimulus(PH_IP, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_IP, 1'b0, 3'd1, 3'd0);
        checkOutput("illegal_pre_err", {31'd0, proto_err}, 32'd0);
        applyStimulus(PH_ILLEGAL, 1'b0, 3'd2, 3'd0);
        checkOutput("illegal_enables",
                    {27'd0, w1_we, x1_re, w1_re, comb_en, x2_re}, 32'd0);
        checkOutput("illegal_proto_err", {31'd0, proto_err}, {31'd0, CHK_EN});
        checkOutput("illegal_err_code", {29'd0, err_code}, CHK_EN ? 32'd1 : 32'd0);
        applyStimulus(PH_IP, 1'b0, 3'd3, 3'd0);
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        checkOutput("illegal_sticky_err", {31'd0, proto_err}, {31'd0, CHK_EN});
        checkOutput("illegal_sticky_code", {29'd0, err_code}, CHK_EN ? 32'd1 : 32'd0);

        // ---- INIT straight to COMB ----
        doReset();
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 8; k++) applyStimulus(PH_INIT, 1'b0, 3'(k), 3'd0);
        applyStimulus(PH_COMB, 1'b0, 3'd0, 3'd0);
        checkOutput("trans_proto_err", {31'd0, proto_err}, {31'd0, CHK_EN});
        checkOutput("trans_err_code", {29'd0, err_code}, CHK_EN ? 32'd2 : 32'd0);

        // ---- Address skip inside IP ----
        doReset();
        runLegalToPipe();
        applyStimulus(PH_IP, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_IP, 1'b0, 3'd1, 3'd0);
        applyStimulus(PH_IP, 1'b0, 3'd2, 3'd0);
        checkOutput("skip_pre_err", {31'd0, proto_err}, 32'd0);
        applyStimulus(PH_IP, 1'b0, 3'd4, 3'd0);
        checkOutput("skip_proto_err", {31'd0, proto_err}, {31'd0, CHK_EN});
        checkOutput("skip_err_code", {29'd0, err_code}, CHK_EN ? 32'd3 : 32'd0);

        // ---- Short INIT phase ----
        doReset();
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 5; k++) applyStimulus(PH_INIT, 1'b0, 3'(k), 3'd0);
        applyStimulus(PH_INIT_IP, 1'b0, 3'd0, 3'd0);
        checkOutput("short_proto_err", {31'd0, proto_err}, {31'd0, CHK_EN});
        checkOutput("short_err_code", {29'd0, err_code}, CHK_EN ? 32'd4 : 32'd0);

        // ---- Abort from IP to IDLE is legal ----
        doReset();
        runLegalToPipe();
        applyStimulus(PH_IP, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_IP, 1'b0, 3'd1, 3'd0);
        applyStimulus(PH_IP, 1'b0, 3'd2, 3'd0);
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        applyStimulus(PH_IDLE, 1'b0, 3'd0, 3'd0);
        checkOutput("abort_proto_err", {31'd0, proto_err}, 32'd0);
        checkOutput("abort_err_code", {29'd0, err_code}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
